// File: rtl/saturn_serial_rx.sv
// saturn_serial_rx
//   Receive end of the debug/console serial link. Samples the asynchronous
//   rx pin through a two-flop synchroniser, reframes 10-bit characters
//   (start, 8 data, stop) and holds each received byte in a single-entry
//   register with a valid/ack handshake. Framing errors and overruns are
//   reported as sticky flags.
//
// Parameters
//   CLKS_PER_BIT  i_clk cycles per serial bit (>= 4)
//   MSB_FIRST     1: first data bit after start is char[7]; 0: LSB first
//
// Ports
//   i_clk            system clock, all state on the rising edge
//   i_reset_n        asynchronous active-low reset
//   i_serial_rx      asynchronous serial line, idle high
//   o_char           received character, stable while o_char_valid=1
//   o_char_valid     holding register full
//   i_char_ack       consumer accepts o_char (ignored while not valid)
//   i_err_clear      clears both sticky error flags
//   o_framing_error  sticky: a stop bit was sampled low
//   o_overrun        sticky: a char completed while the holding register
//                    was full and not being acked
//   o_serial_busy    receiver FSM is not idle
module saturn_serial_rx #(
   parameter int unsigned CLKS_PER_BIT = 40,
   parameter bit          MSB_FIRST    = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_serial_rx,
   output logic [7:0] o_char,
   output logic       o_char_valid,
   input  logic       i_char_ack,
   input  logic       i_err_clear,
   output logic       o_framing_error,
   output logic       o_overrun,
   output logic       o_serial_busy
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic          rx_m;
   logic          rx_s;

   logic [CW-1:0] cnt;
   logic          cnt_clr;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;

   logic          sample_data;
   logic          stop_good;
   logic          stop_bad;
   logic          load_char;
   logic          set_overrun;

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= i_serial_rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_clr     = 1'b0;
      sample_data = 1'b0;
      stop_good   = 1'b0;
      stop_bad    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            // Re-check the line at mid start bit; a high line was a glitch.
            if (cnt == CNT_HALF) begin
               state_nxt = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt == CNT_LAST) begin
               sample_data = 1'b1;
               cnt_clr     = 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (cnt == CNT_LAST) begin
               if (rx_s) begin
                  stop_good = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // Wait out a held-low line so it yields only one framing error.
            if (rx_s) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (state_nxt != state) begin
         cnt_clr = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bit_cnt <= '0;
      end else if (state != S_DATA) begin
         bit_cnt <= '0;
      end else if (sample_data) begin
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // MSB-first shifts in at the bottom so the first bit ends up in [7].
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shreg <= '0;
      end else if (sample_data) begin
         if (MSB_FIRST) begin
            shreg <= {shreg[6:0], rx_s};
         end else begin
            shreg <= {rx_s, shreg[7:1]};
         end
      end
   end

   // A completed char lands if the register is empty or being acked in the
   // same cycle; otherwise it is dropped and reported as an overrun.
   assign load_char   = stop_good & (~o_char_valid | i_char_ack);
   assign set_overrun = stop_good & o_char_valid & ~i_char_ack;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_char       <= '0;
         o_char_valid <= 1'b0;
      end else if (load_char) begin
         o_char       <= shreg;
         o_char_valid <= 1'b1;
      end else if (i_char_ack && o_char_valid) begin
         o_char_valid <= 1'b0;
      end
   end

   // Setting a flag takes priority over a clear in the same cycle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_framing_error <= 1'b0;
         o_overrun       <= 1'b0;
      end else begin
         if (stop_bad) begin
            o_framing_error <= 1'b1;
         end else if (i_err_clear) begin
            o_framing_error <= 1'b0;
         end
         if (set_overrun) begin
            o_overrun <= 1'b1;
         end else if (i_err_clear) begin
            o_overrun <= 1'b0;
         end
      end
   end

   assign o_serial_busy = (state != S_IDLE);

endmodule

// File: tb/tb_saturn_serial_rx.sv
// tb_saturn_serial_rx
//   Bench for saturn_serial_rx. Two instances share clock, reset, line and
//   handshake inputs: one MSB-first, one LSB-first. Expected values come from
//   a frame-level model of the holding register and sticky flags.
module tb_saturn_serial_rx;

   localparam int CPB = 16;
   // Cycle index within a frame (line falls at index 0) at which the stop bit
   // is sampled: 2 synchroniser cycles, 1 idle-detect cycle, half a start
   // bit, 8 data bits and one more full bit period minus the sampling cycle.
   localparam int STOP_C = 2 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       ack;
   logic       clr;

   logic [7:0] char_m, char_l;
   logic       val_m, val_l, fe_m, fe_l, ov_m, ov_l, busy_m, busy_l;

   int n_checks = 0;
   int n_pass   = 0;

   // Frame-level reference model (MSB-first instance)
   logic       m_valid;
   logic [7:0] m_char;
   logic       m_fe;
   logic       m_ov;

   always #5 clk = ~clk;

   saturn_serial_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut_msb (
      .i_clk(clk), .i_reset_n(rst_n), .i_serial_rx(rx),
      .o_char(char_m), .o_char_valid(val_m), .i_char_ack(ack),
      .i_err_clear(clr), .o_framing_error(fe_m), .o_overrun(ov_m),
      .o_serial_busy(busy_m)
   );

   saturn_serial_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_lsb (
      .i_clk(clk), .i_reset_n(rst_n), .i_serial_rx(rx),
      .o_char(char_l), .o_char_valid(val_l), .i_char_ack(ack),
      .i_err_clear(clr), .o_framing_error(fe_l), .o_overrun(ov_l),
      .o_serial_busy(busy_l)
   );

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_char  = 8'h00;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
   endtask

   // One complete frame outcome; acked means ack was high in the stop-sample cycle.
   task automatic model_frame(input logic [7:0] b, input bit stop, input bit acked);
      if (!stop) begin
         m_fe = 1'b1;
         if (acked) m_valid = 1'b0;
      end else if (!m_valid || acked) begin
         m_valid = 1'b1;
         m_char  = b;
      end else begin
         m_ov = 1'b1;
      end
   endtask

   // Drives one 10-bit frame starting at posedge+1; leaves rx at the stop value.
   task automatic send_frame(input logic [7:0] b, input bit msb, input bit stop, input int ack_c);
      logic [9:0] seq;
      seq[0] = 1'b0;
      for (int i = 0; i < 8; i++) seq[i+1] = msb ? b[7-i] : b[i];
      seq[9] = stop;
      for (int c = 0; c < 10 * CPB; c++) begin
         rx  = seq[c / CPB];
         ack = (c == ack_c);
         @(posedge clk);
         #1;
      end
      ack = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      idle(1);
      ack = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      n_checks++; if (char_m !== 8'h00) $display("FAIL reset_char: got %h expected 00", char_m); else n_pass++;
      n_checks++; if (val_m !== 1'b0) $display("FAIL reset_valid: got %b expected 0", val_m); else n_pass++;
      n_checks++; if (fe_m !== 1'b0) $display("FAIL reset_fe: got %b expected 0", fe_m); else n_pass++;
      n_checks++; if (ov_m !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", ov_m); else n_pass++;
      n_checks++; if (busy_m !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_m); else n_pass++;
      rst_n = 1'b1;
      model_reset();
      idle(4);
      n_checks++; if (busy_m !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy_m); else n_pass++;
   endtask

   task automatic test_basic();
      send_frame(8'h41, 1'b1, 1'b1, -1);
      model_frame(8'h41, 1'b1, 1'b0);
      n_checks++; if (val_m !== m_valid) $display("FAIL basic_valid: got %b expected %b", val_m, m_valid); else n_pass++;
      n_checks++; if (char_m !== m_char) $display("FAIL basic_char: got %h expected %h", char_m, m_char); else n_pass++;
      n_checks++; if (fe_m !== m_fe || ov_m !== m_ov) $display("FAIL basic_flags: got fe=%b ov=%b expected fe=%b ov=%b", fe_m, ov_m, m_fe, m_ov); else n_pass++;
      pulse_ack();
      m_valid = 1'b0;
      n_checks++; if (val_m !== m_valid) $display("FAIL basic_ack: got %b expected %b", val_m, m_valid); else n_pass++;
   endtask

   task automatic test_glitch();
      int busy_n = 0;
      for (int c = 0; c < 30; c++) begin
         rx = (c < 4) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         if (busy_m) busy_n++;
      end
      n_checks++; if (busy_n != CPB / 2) $display("FAIL glitch_busy_len: got %0d expected %0d", busy_n, CPB / 2); else n_pass++;
      n_checks++; if (busy_m !== 1'b0) $display("FAIL glitch_idle: got %b expected 0", busy_m); else n_pass++;
      n_checks++; if (val_m !== m_valid || fe_m !== m_fe || ov_m !== m_ov) $display("FAIL glitch_outputs: got v=%b fe=%b ov=%b expected v=%b fe=%b ov=%b", val_m, fe_m, ov_m, m_valid, m_fe, m_ov); else n_pass++;
   endtask

   task automatic test_framing();
      send_frame(8'h55, 1'b1, 1'b0, -1);
      model_frame(8'h55, 1'b0, 1'b0);
      n_checks++; if (fe_m !== m_fe) $display("FAIL framing_set: got %b expected %b", fe_m, m_fe); else n_pass++;
      n_checks++; if (val_m !== m_valid) $display("FAIL framing_novalid: got %b expected %b", val_m, m_valid); else n_pass++;
      idle(20 * CPB);
      pulse_clr();
      m_fe = 1'b0;
      n_checks++; if (fe_m !== m_fe) $display("FAIL framing_clear: got %b expected %b", fe_m, m_fe); else n_pass++;
      idle(20 * CPB);
      n_checks++; if (fe_m !== 1'b0) $display("FAIL framing_once: got %b expected 0", fe_m); else n_pass++;
      n_checks++; if (busy_m !== 1'b1) $display("FAIL framing_held_busy: got %b expected 1", busy_m); else n_pass++;
      rx = 1'b1;
      idle(CPB);
      n_checks++; if (busy_m !== 1'b0 || val_m !== 1'b0 || fe_m !== 1'b0) $display("FAIL framing_release: got busy=%b v=%b fe=%b expected 0 0 0", busy_m, val_m, fe_m); else n_pass++;
   endtask

   task automatic test_overrun();
      send_frame(8'h12, 1'b1, 1'b1, -1);
      model_frame(8'h12, 1'b1, 1'b0);
      send_frame(8'h34, 1'b1, 1'b1, -1);
      model_frame(8'h34, 1'b1, 1'b0);
      n_checks++; if (char_m !== m_char) $display("FAIL overrun_keep_char: got %h expected %h", char_m, m_char); else n_pass++;
      n_checks++; if (ov_m !== m_ov) $display("FAIL overrun_flag: got %b expected %b", ov_m, m_ov); else n_pass++;
      send_frame(8'h34, 1'b1, 1'b1, STOP_C);
      model_frame(8'h34, 1'b1, 1'b1);
      n_checks++; if (char_m !== m_char || val_m !== m_valid) $display("FAIL overrun_ack_char: got %h/%b expected %h/%b", char_m, val_m, m_char, m_valid); else n_pass++;
      n_checks++; if (ov_m !== m_ov) $display("FAIL overrun_ack_flag: got %b expected %b", ov_m, m_ov); else n_pass++;
      pulse_clr();
      m_ov = 1'b0;
      n_checks++; if (ov_m !== m_ov) $display("FAIL overrun_clear: got %b expected %b", ov_m, m_ov); else n_pass++;
      pulse_ack();
      m_valid = 1'b0;
      n_checks++; if (val_m !== m_valid) $display("FAIL overrun_final_ack: got %b expected %b", val_m, m_valid); else n_pass++;
   endtask

   task automatic test_random();
      for (int f = 0; f < 16; f++) begin
         logic [7:0] b;
         bit         stop;
         int         ack_c;
         b     = 8'($urandom);
         stop  = ($urandom_range(0, 5) != 0);
         ack_c = ($urandom_range(0, 3) == 0) ? STOP_C : -1;
         send_frame(b, 1'b1, stop, ack_c);
         model_frame(b, stop, ack_c >= 0);
         if (!stop) begin
            rx = 1'b1;
            idle(CPB);
         end
         n_checks++; if (val_m !== m_valid) $display("FAIL rand_valid[%0d]: got %b expected %b", f, val_m, m_valid); else n_pass++;
         n_checks++; if (char_m !== m_char) $display("FAIL rand_char[%0d]: got %h expected %h", f, char_m, m_char); else n_pass++;
         n_checks++; if (fe_m !== m_fe) $display("FAIL rand_fe[%0d]: got %b expected %b", f, fe_m, m_fe); else n_pass++;
         n_checks++; if (ov_m !== m_ov) $display("FAIL rand_ovr[%0d]: got %b expected %b", f, ov_m, m_ov); else n_pass++;
         if ($urandom_range(0, 1) == 0) begin
            pulse_ack();
            m_valid = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) begin
            pulse_clr();
            m_fe = 1'b0;
            m_ov = 1'b0;
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [9:0] seq;
      logic [7:0] b;
      b = 8'($urandom);
      seq[0] = 1'b0;
      for (int i = 0; i < 8; i++) seq[i+1] = b[7-i];
      seq[9] = 1'b1;
      for (int c = 0; c < 5 * CPB + CPB / 2; c++) begin
         rx = seq[c / CPB];
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      rx    = 1'b1;
      idle(3);
      rst_n = 1'b1;
      model_reset();
      idle(12 * CPB);
      n_checks++; if (val_m !== 1'b0 || busy_m !== 1'b0) $display("FAIL midreset_no_partial: got v=%b busy=%b expected 0 0", val_m, busy_m); else n_pass++;
      send_frame(8'hA5, 1'b1, 1'b1, -1);
      model_frame(8'hA5, 1'b1, 1'b0);
      n_checks++; if (char_m !== m_char || val_m !== m_valid) $display("FAIL midreset_char: got %h/%b expected %h/%b", char_m, val_m, m_char, m_valid); else n_pass++;
      n_checks++; if (fe_m !== m_fe || ov_m !== m_ov) $display("FAIL midreset_flags: got fe=%b ov=%b expected fe=%b ov=%b", fe_m, ov_m, m_fe, m_ov); else n_pass++;
      pulse_ack();
   endtask

   task automatic test_lsb();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      model_reset();
      idle(2);
      n_checks++; if (busy_l !== 1'b0 || val_l !== 1'b0) $display("FAIL lsb_reset: got busy=%b v=%b expected 0 0", busy_l, val_l); else n_pass++;
      send_frame(8'h80, 1'b0, 1'b1, -1);
      n_checks++; if (char_l !== 8'h80 || val_l !== 1'b1) $display("FAIL lsb_0x80: got %h/%b expected 80/1", char_l, val_l); else n_pass++;
      pulse_ack();
      for (int f = 0; f < 4; f++) begin
         logic [7:0] b;
         b = 8'($urandom);
         send_frame(b, 1'b0, 1'b1, -1);
         n_checks++; if (char_l !== b || val_l !== 1'b1) $display("FAIL lsb_rand[%0d]: got %h/%b expected %h/1", f, char_l, val_l, b); else n_pass++;
         pulse_ack();
      end
      n_checks++; if (fe_l !== 1'b0 || ov_l !== 1'b0) $display("FAIL lsb_flags: got fe=%b ov=%b expected 0 0", fe_l, ov_l); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      ack   = 1'b0;
      clr   = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_overrun();
      test_random();
      test_reset_midframe();
      test_lsb();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/saturn_serial_rx.md
Name: saturn_serial_rx

Overview:
UART-style serial receiver, the receive end of the debug/console serial link. It samples the asynchronous rx line, reframes 10-bit characters (start, 8 data, stop) and presents each byte in a single-entry holding register with a valid/ack handshake. It flags framing errors and overruns, and sits between the board rx pin and the debug console logic.

Parameters:
CLKS_PER_BIT, 40, i_clk cycles per serial bit (>=4); 40 gives 115200 baud on the team's board clock; benches use 16.
MSB_FIRST, 1, 1: first data bit after start is char[7] (team link convention); 0: LSB first.

Ports:
i_clk  input  1  system clock; all state on rising edge.
i_reset_n  input  1  asynchronous, active-low reset.
i_serial_rx  input  1  asynchronous serial line; idle high.
o_char  output  8  received character; stable while o_char_valid=1.
o_char_valid  output  1  holding register full.
i_char_ack  input  1  consumer accepts o_char; meaningful only while o_char_valid=1.
i_err_clear  input  1  clears both sticky error flags.
o_framing_error  output  1  sticky: a stop bit sampled low.
o_overrun  output  1  sticky: a char completed while the holding register was full and not acked.
o_serial_busy  output  1  1 whenever the FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, bit counter=0, cycle counter=0, both synchroniser flops=1, o_char=8'h00, o_char_valid=0, o_framing_error=0, o_overrun=0, o_serial_busy=0.
- i_serial_rx passes through a 2-flop synchroniser; all sampling uses the second flop (rx_s). Line-to-rx_s latency: 2 cycles.
- Cycle counter width: clog2(CLKS_PER_BIT). It resets to 0 on every state entry and counts up each cycle.
- IDLE: rx_s=0 -> START.
- START: at count CLKS_PER_BIT/2-1 (mid start bit), rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch rejected, no flags).
- DATA: sample rx_s every CLKS_PER_BIT cycles (count CLKS_PER_BIT-1), i.e. at mid-bit.
  - Shift order per MSB_FIRST.
  - After 8 samples -> STOP.
- STOP: sample at count CLKS_PER_BIT-1.
  - rx_s=1 -> deliver; -> IDLE.
  - rx_s=0 -> o_framing_error=1, no delivery -> BREAK.
- BREAK: stay until rx_s=1, then -> IDLE. A held-low line produces exactly one framing error.
- Deliver: takes effect on the cycle after the stop sample.
  - o_char_valid=0, or o_char_valid=1 with i_char_ack=1 in the stop-sample cycle: load o_char, o_char_valid=1.
  - o_char_valid=1 without ack: new char discarded, o_char unchanged, o_overrun=1.
- Ack: i_char_ack with o_char_valid=1 clears o_char_valid next cycle, unless a delivery lands in that same cycle; then valid stays 1 with the new char. Ack with valid=0 is ignored.
- i_err_clear clears both flags next cycle. A same-cycle set of a flag wins over the clear.
- A line going low in the cycle the FSM returns to IDLE starts a new frame with no lost cycle (back-to-back frames).
- Reset mid-frame aborts the frame; no partial char is delivered.

Test Plan:
- CLKS_PER_BIT=16, MSB_FIRST=1, send 0x41 (line: 0,0,1,0,0,0,0,0,1,1) -> o_char_valid rises with o_char=8'h41, no flags; ack -> valid=0 next cycle.
- Line low for 4 cycles, then high -> FSM returns to IDLE, o_char_valid=0, no flags, o_serial_busy high only transiently.
- Send 0x55 with stop bit 0, line held low 40 bit times, then high -> o_framing_error=1 exactly once, no valid; i_err_clear -> flag 0.
- Send 0x12 then 0x34 back-to-back with no ack -> o_char=8'h12 retained, o_overrun=1; send again with ack asserted in the stop-sample cycle -> o_char=8'h34, o_overrun unchanged.
- MSB_FIRST=0, send 0x80 LSB first -> o_char=8'h80.
- Assert i_reset_n=0 during bit 4 of a frame, release, then send 0xA5 -> only 8'hA5 delivered, flags 0.
